alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered stage directly downstream of the ALU. Captures the ALU result and its C/N/Z/V/DC/DHC/HC outputs and, for ADC/SBC in decimal mode, applies a one-cycle BCD correction. Holds the result and the N/V/Z/C status flags until the next operation. Other stages read the result register and flags; a one-cycle `done` pulse marks each update.

## Interface
Parameters: none (8-bit datapath is fixed).

- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  capture request; sampled only in IDLE
- `alu_out`  in  8  ALU result
- `alu_c`, `alu_n`, `alu_z`, `alu_v`  in  1 each  ALU carry/negative/zero/overflow
- `alu_dc`, `alu_dhc`  in  1 each  ALU decimal carry / decimal half carry
- `alu_hc`  in  1  ALU binary half carry (carry out of bit 3)
- `arith`  in  1  operation is ADC/SBC
- `sub`  in  1  operation is SBC (ALU computed A + ~B + C); only meaningful when `arith`=1
- `D`  in  1  decimal mode flag
- `flag_we`  in  4  flag load mask {N,V,Z,C}
- `result`  out  8  registered result
- `N`, `V`, `Z`, `C`  out  1 each  registered status flags
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse: result and flags updated

## Operation
- States: IDLE, ADJ, DONE. Reset value: IDLE.
- **IDLE, `start`=1, and not (`D` & `arith`):**
  - `result` <= `alu_out`.
  - Each flag with its `flag_we` bit set <= the matching `alu_*` input.
  - Next state DONE.
- **IDLE, `start`=1, `D`=1, `arith`=1:**
  - Capture into internal holding registers: `alu_out`, `alu_c`, `alu_dc`, `alu_dhc`, `alu_hc`, `sub`, `flag_we`.
  - N/V/Z flags with `flag_we` set <= `alu_n`/`alu_v`/`alu_z` at this edge. This gives NMOS behaviour: N/V/Z come from the binary result.
  - Next state ADJ.
- **ADJ, ADC (`sub`=0):**
  - lo = dhc | hc; hi = dc | c.
  - `result` <= held_out + (lo ? 0x06 : 0) + (hi ? 0x60 : 0), mod 256.
  - C (if its we bit is set) <= hi.
- **ADJ, SBC (`sub`=1):**
  - `result` <= held_out − (hc ? 0 : 0x06) − (c ? 0 : 0x60), mod 256.
  - C (if its we bit is set) <= c (binary borrow-complement).
- ADJ always goes to DONE. DONE always goes to IDLE.
- `start` outside IDLE is ignored and is not queued.
- Flags whose `flag_we` bit is clear hold their value.
- `D`/`arith`/`sub` are sampled only with `start` in IDLE. Later changes do not affect an operation in flight.

## Timing
- Reset (async, `rst_n`=0):
  - `result`=0x00; N=V=Z=C=0; `busy`=0; `done`=0; holding registers 0; state IDLE.
  - Takes effect immediately and aborts any operation in flight. No `done` is produced for the aborted operation.
- Binary path: `start` at edge k → `result`/flags valid and `done`=1 after edge k+1 (latency 1). `busy`=1 for that same cycle only.
- Decimal path:
  - N/V/Z valid after edge k+1.
  - `result` and C valid after edge k+2, with `done`=1 for that cycle (latency 2).
  - `busy`=1 for two cycles.
- `done` and `busy` are registered (decoded from state). `done`=1 exactly in DONE.
- The earliest accepted back-to-back `start` is in the cycle after DONE. Maximum throughput is one op per 2 cycles (binary) or 3 cycles (decimal).
- `result` is stable in IDLE. In the decimal path it keeps its previous value through ADJ.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ADJ → immediately `result`=0x00, flags 0, `busy`=0, and no `done` afterwards.
- **Binary ADC:** `alu_out`=0x80, n=1, v=1, z=0, c=0, `flag_we`=4'hF, D=0, start → one cycle later `result`=0x80, N=1, V=1, Z=0, C=0, `done`=1.
- **Decimal ADC 0x99+0x01:** `alu_out`=0x9A, dhc=1, dc=1, hc=0, c=0, D=1, arith=1, sub=0 → after 2 cycles `result`=0x00, C=1, Z=0 (binary Z), `done`=1.
- **Decimal ADC 0x09+0x09:** `alu_out`=0x12, hc=1, dhc=0, dc=0, c=0 → `result`=0x18, C=0.
- **Decimal SBC:**
  - 0x00−0x01 (C=1): `alu_out`=0xFF, c=0, hc=0 → `result`=0x99, C=0.
  - 0x10−0x01: `alu_out`=0x0F, c=1, hc=0 → `result`=0x09, C=1.
- **Masking and ignored start:** `flag_we`=4'b0001 leaves N/V/Z unchanged. A `start` pulsed while `busy`=1 produces no extra `done` and no `result` change.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// Bus between the ALU and its result stage: ALU outputs and operation
// qualifiers going in, registered result, status flags and handshake coming out.
interface alu_result_stage_if;
  logic       start;
  logic [7:0] alu_out;
  logic       alu_c;
  logic       alu_n;
  logic       alu_z;
  logic       alu_v;
  logic       alu_dc;
  logic       alu_dhc;
  logic       alu_hc;
  logic       arith;
  logic       sub;
  logic       D;
  logic [3:0] flag_we;
  logic [7:0] result;
  logic       N;
  logic       V;
  logic       Z;
  logic       C;
  logic       busy;
  logic       done;

  modport master (
    output start, alu_out, alu_c, alu_n, alu_z, alu_v, alu_dc, alu_dhc, alu_hc,
           arith, sub, D, flag_we,
    input  result, N, V, Z, C, busy, done
  );

  modport slave (
    input  start, alu_out, alu_c, alu_n, alu_z, alu_v, alu_dc, alu_dhc, alu_hc,
           arith, sub, D, flag_we,
    output result, N, V, Z, C, busy, done
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result/flag stage with a one-cycle BCD correction step for
// decimal-mode ADC/SBC; N/V/Z always come from the binary ALU result.
module alu_result_stage (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADJ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] result_q, result_d;
  logic       n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
  logic [7:0] held_out_q, held_out_d;
  logic       held_c_q, held_c_d, held_dc_q, held_dc_d;
  logic       held_dhc_q, held_dhc_d, held_hc_q, held_hc_d;
  logic       held_sub_q, held_sub_d;
  logic [3:0] held_we_q, held_we_d;
  logic       busy_q, busy_d, done_q, done_d;

  logic       lo_s, hi_s;
  logic [7:0] adj_add_s, adj_sub_s;

  // BCD correction of the held binary result (flag_we bit order {N,V,Z,C})
  always_comb begin
    lo_s      = held_dhc_q | held_hc_q;
    hi_s      = held_dc_q | held_c_q;
    adj_add_s = held_out_q + (lo_s ? 8'h06 : 8'h00) + (hi_s ? 8'h60 : 8'h00);
    adj_sub_s = held_out_q - (held_hc_q ? 8'h00 : 8'h06) - (held_c_q ? 8'h00 : 8'h60);
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    n_d        = n_q;
    v_d        = v_q;
    z_d        = z_q;
    c_d        = c_q;
    held_out_d = held_out_q;
    held_c_d   = held_c_q;
    held_dc_d  = held_dc_q;
    held_dhc_d = held_dhc_q;
    held_hc_d  = held_hc_q;
    held_sub_d = held_sub_q;
    held_we_d  = held_we_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d = bus.flag_we[3] ? bus.alu_n : n_q;
          v_d = bus.flag_we[2] ? bus.alu_v : v_q;
          z_d = bus.flag_we[1] ? bus.alu_z : z_q;
          if (bus.D && bus.arith) begin
            held_out_d = bus.alu_out;
            held_c_d   = bus.alu_c;
            held_dc_d  = bus.alu_dc;
            held_dhc_d = bus.alu_dhc;
            held_hc_d  = bus.alu_hc;
            held_sub_d = bus.sub;
            held_we_d  = bus.flag_we;
            state_d    = ADJ;
          end else begin
            result_d = bus.alu_out;
            c_d      = bus.flag_we[0] ? bus.alu_c : c_q;
            state_d  = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADJ: begin
        // SBC carry is the binary borrow-complement; ADC carry is the decimal carry
        if (held_sub_q) begin
          result_d = adj_sub_s;
          c_d      = held_we_q[0] ? held_c_q : c_q;
        end else begin
          result_d = adj_add_s;
          c_d      = held_we_q[0] ? hi_s : c_q;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      result_q   <= 8'h00;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      held_out_q <= 8'h00;
      held_c_q   <= 1'b0;
      held_dc_q  <= 1'b0;
      held_dhc_q <= 1'b0;
      held_hc_q  <= 1'b0;
      held_sub_q <= 1'b0;
      held_we_q  <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      n_q        <= n_d;
      v_q        <= v_d;
      z_q        <= z_d;
      c_q        <= c_d;
      held_out_q <= held_out_d;
      held_c_q   <= held_c_d;
      held_dc_q  <= held_dc_d;
      held_dhc_q <= held_dhc_d;
      held_hc_q  <= held_hc_d;
      held_sub_q <= held_sub_d;
      held_we_q  <= held_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.N      = n_q;
  assign bus.V      = v_q;
  assign bus.Z      = z_q;
  assign bus.C      = c_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed operations push expected
// {result,N,V,Z,C}; a monitor pops and compares on every done pulse.
module tb_alu_result_stage;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  typedef struct {
    logic [7:0] res;
    logic       n;
    logic       v;
    logic       z;
    logic       c;
  } exp_t;

  exp_t exp_q[$];

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_result_flags",
              {20'd0, bus.result, bus.N, bus.V, bus.Z, bus.C},
              {20'd0, e.res, e.n, e.v, e.z, e.c});
      end
    end
  end

  task automatic push_exp(input logic [7:0] r, input logic n, input logic v,
                          input logic z, input logic c);
    exp_t e;
    e.res = r; e.n = n; e.v = v; e.z = z; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic set_inputs(input logic [7:0] out, input logic n, input logic v,
                            input logic z, input logic c, input logic dc,
                            input logic dhc, input logic hc, input logic ar,
                            input logic sb, input logic d, input logic [3:0] we);
    bus.alu_out = out; bus.alu_n = n; bus.alu_v = v; bus.alu_z = z;
    bus.alu_c = c; bus.alu_dc = dc; bus.alu_dhc = dhc; bus.alu_hc = hc;
    bus.arith = ar; bus.sub = sb; bus.D = d; bus.flag_we = we;
  endtask

  // Pulse start for one edge; returns at the negedge after the capture edge
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_inputs(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    check("reset_state", {24'd0, bus.result},
          32'd0);
    check("reset_flags_busy_done",
          {26'd0, bus.N, bus.V, bus.Z, bus.C, bus.busy, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Binary ADC, latency 1, busy for one cycle
    set_inputs(8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
    push_exp(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_start();
    check("bin_busy_done", {30'd0, bus.busy, bus.done}, 32'd3);
    @(negedge clk);
    check("bin_back_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    // Decimal ADC 0x99+0x01; N/V/Z one cycle early, result held through ADJ
    set_inputs(8'h9A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
    push_exp(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_start();
    check("dec_adj_nvz", {29'd0, bus.N, bus.V, bus.Z}, 32'd4);
    check("dec_adj_result_held", {24'd0, bus.result}, 32'h80);
    check("dec_adj_busy_done", {30'd0, bus.busy, bus.done}, 32'd2);
    wait_idle();

    // Decimal ADC 0x09+0x09
    set_inputs(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF);
    push_exp(8'h18, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    wait_idle();

    // Decimal SBC 0x00-0x01
    set_inputs(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    push_exp(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    wait_idle();

    // Decimal SBC 0x10-0x01
    set_inputs(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    push_exp(8'h09, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_start();
    wait_idle();

    // Only C writable: N/V/Z keep their previous zeros
    set_inputs(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    push_exp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    wait_idle();

    // Decimal op with start held and inputs changed while busy
    set_inputs(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF);
    push_exp(8'h18, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    set_inputs(8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("no_extra_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
    end
    check("result_stable_idle", {24'd0, bus.result}, 32'h18);

    // Reset during ADJ aborts with no done
    set_inputs(8'h9A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
    pulse_start();
    rst_n = 1'b0;
    #1;
    check("mid_reset_result", {24'd0, bus.result}, 32'd0);
    check("mid_reset_flags_busy_done",
          {26'd0, bus.N, bus.V, bus.Z, bus.C, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_after_abort", {31'd0, bus.done}, 32'd0);
    end

    // Binary op after reset still works
    set_inputs(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
    push_exp(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_start();
    wait_idle();
    repeat (2) @(negedge clk);

    check("all_expected_done_seen", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
